// File: rtl/seg7_reader_if.sv
// seg7_reader_if: decoded-digit stream with valid/ready handshake and status pulses.
interface seg7_reader_if;
    logic [3:0] digit;
    logic       digit_valid;
    logic       digit_ready;
    logic       err;
    logic       ovr;
    modport master (output digit, digit_valid, err, ovr, input digit_ready);
    modport slave  (input digit, digit_valid, err, ovr, output digit_ready);
endinterface

// File: rtl/seg7_reader.sv
// seg7_reader: debounces active-low 7447 segment lines and decodes stable patterns
// back to 4-bit codes behind a one-entry valid/ready holding register.
module seg7_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       seg_n,
    seg7_reader_if.master    out
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [6:0]    seg_q;
    logic [CW-1:0] cnt;
    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [3:0]    digit;
    logic [3:0]    code;
    logic          code_ok;
    logic          same;
    logic          accept;
    logic          acc_ok;
    logic          hs;
    logic          load;
    logic          err;
    logic          ovr;

    always_comb begin
        code    = 4'd0;
        code_ok = 1'b1;
        case (seg_n)
            7'h01: code = 4'd0;
            7'h4F: code = 4'd1;
            7'h12: code = 4'd2;
            7'h06: code = 4'd3;
            7'h4C: code = 4'd4;
            7'h24: code = 4'd5;
            7'h60: code = 4'd6;
            7'h0F: code = 4'd7;
            7'h00: code = 4'd8;
            7'h0C: code = 4'd9;
            7'h72: code = 4'd10;
            7'h66: code = 4'd11;
            7'h5C: code = 4'd12;
            7'h34: code = 4'd13;
            7'h70: code = 4'd14;
            7'h7F: code = 4'd15;
            default: code_ok = 1'b0;
        endcase
    end

    // cnt saturates at STABLE_CYCLES, so the accept compare hits only once per run
    always_comb begin
        same      = seg_n == seg_q;
        accept    = same && (cnt == CW'(STABLE_CYCLES - 1));
        acc_ok    = accept && code_ok;
        hs        = (state == FULL) && out.digit_ready;
        load      = acc_ok && ((state == EMPTY) || out.digit_ready);
        state_nxt = acc_ok ? FULL : (hs ? EMPTY : state);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 7'h7F;
            cnt   <= '0;
            state <= EMPTY;
            digit <= 4'd0;
            err   <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            seg_q <= seg_n;
            cnt   <= !same ? '0 : (cnt < CW'(STABLE_CYCLES) ? cnt + 1'b1 : cnt);
            state <= state_nxt;
            digit <= load ? code : digit;
            err   <= accept && !code_ok;
            ovr   <= acc_ok && (state == FULL) && !out.digit_ready;
        end
    end

    assign out.digit       = digit;
    assign out.digit_valid = state == FULL;
    assign out.err         = err;
    assign out.ovr         = ovr;
endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: directed stimulus with a run-length based reference model and
// literal spot checks for seg7_reader.
module tb_seg7_reader;
    localparam int S = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_n = 7'h7F;
    int vectors = 0;
    int miscompares = 0;
    int n_err = 0;
    int n_ovr = 0;

    seg7_reader_if bus ();
    seg7_reader #(.STABLE_CYCLES(S)) dut (.clk(clk), .rst_n(rst_n), .seg_n(seg_n), .out(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a pattern is accepted when its run of identical edge samples
    // (reset counts as one 7F sample) reaches exactly S+1.
    logic [6:0] tbl [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h60, 7'h0F,
                             7'h00, 7'h0C, 7'h72, 7'h66, 7'h5C, 7'h34, 7'h70, 7'h7F};
    logic [6:0] run_val = 7'h7F;
    int         run_len = 1;
    bit         mv = 0, me = 0, mo = 0;
    logic [3:0] md = 4'd0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                run_val = 7'h7F; run_len = 1; mv = 0; md = 4'd0; me = 0; mo = 0;
            end else begin
                bit ok;
                bit rdy;
                logic [3:0] c;
                ok = 0; c = 4'd0; rdy = bus.digit_ready;
                if (seg_n == run_val) run_len = (run_len > S + 1) ? run_len : run_len + 1;
                else begin run_val = seg_n; run_len = 1; end
                for (int i = 0; i < 16; i++) if (tbl[i] == run_val) begin ok = 1; c = 4'(i); end
                me = 0; mo = 0;
                if (run_len == S + 1 && !ok) me = 1;
                if (run_len == S + 1 && ok) begin
                    if (mv && !rdy) mo = 1;
                    else begin mv = 1; md = c; end
                end else if (mv && rdy) mv = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("digit_valid", bus.digit_valid, mv);
        check("err", bus.err, me);
        check("ovr", bus.ovr, mo);
        if (mv) check("digit", bus.digit, md);
    end

    task automatic step(input logic [6:0] v, input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            seg_n = v;
            bus.digit_ready = r;
            @(negedge clk);
            if (bus.err) n_err++;
            if (bus.ovr) n_ovr++;
        end
    endtask

    initial begin
        bus.digit_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_valid", bus.digit_valid, 0);
        rst_n = 1'b1;
        // blank after reset reports 15 on the 4th edge
        step(7'h7F, 0, 3);
        check("blank_not_yet", bus.digit_valid, 0);
        step(7'h7F, 0, 1);
        check("blank_valid", bus.digit_valid, 1);
        check("blank_digit", bus.digit, 15);
        n_err = 0; n_ovr = 0;
        step(7'h7F, 0, 6);
        check("blank_held", bus.digit_valid, 1);
        check("blank_no_pulses", n_err + n_ovr, 0);
        step(7'h7F, 1, 1);
        check("blank_consumed", bus.digit_valid, 0);
        // 06 -> code 3
        step(7'h06, 0, 4);
        check("three_not_yet", bus.digit_valid, 0);
        step(7'h06, 0, 1);
        check("three_digit", bus.digit, 3);
        step(7'h06, 0, 5);
        step(7'h06, 1, 1);
        check("three_dropped", bus.digit_valid, 0);
        step(7'h06, 0, 6);
        check("three_no_repeat", bus.digit_valid, 0);
        // glitch to 01 for two cycles is never reported
        step(7'h12, 1, 6);
        step(7'h01, 1, 2);
        step(7'h12, 1, 4);
        check("glitch_before", bus.digit_valid, 0);
        step(7'h12, 0, 1);
        check("glitch_return_digit", bus.digit, 2);
        step(7'h12, 1, 1);
        // invalid pattern while FULL
        step(7'h34, 0, 6);
        check("thirteen", bus.digit, 13);
        n_err = 0; n_ovr = 0;
        step(7'h55, 0, 8);
        check("err_once", n_err, 1);
        check("err_no_ovr", n_ovr, 0);
        check("err_keeps_digit", bus.digit, 13);
        step(7'h55, 1, 1);
        // overflow while holding 8
        step(7'h00, 0, 6);
        check("eight", bus.digit, 8);
        n_ovr = 0;
        step(7'h0C, 0, 6);
        check("ovr_once", n_ovr, 1);
        check("ovr_keeps_8", bus.digit, 8);
        step(7'h01, 0, 2);
        n_ovr = 0;
        step(7'h0C, 0, 4);
        step(7'h0C, 1, 1);
        check("swap_digit", bus.digit, 9);
        check("swap_valid", bus.digit_valid, 1);
        check("swap_no_ovr", n_ovr, 0);
        // async reset mid-count while FULL
        step(7'h06, 0, 2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", bus.digit_valid, 0);
        check("rst_err", bus.err, 0);
        check("rst_ovr", bus.ovr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(7'h06, 0, 4);
        check("rst_not_yet", bus.digit_valid, 0);
        step(7'h06, 0, 1);
        check("rst_rereport", bus.digit, 3);
        step(7'h06, 1, 3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seg7_reader.md
Name: seg7_reader

Overview:
- Receive-side counterpart of the 7447 BCD-to-7-segment decoder.
- Samples the active-low 7-segment lines of a 7447-style driver and requires each pattern to be stable for STABLE_CYCLES clocks.
- Decodes the stable pattern back to its 4-bit code (0-15) and presents it on a one-entry valid/ready output.
- Used for loopback checking of display drivers and for reading segment buses back into logic.

Parameters:
- STABLE_CYCLES, 4: consecutive matching samples needed before a pattern is accepted. Legal range 1..255. Counter width is clog2(STABLE_CYCLES+1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg_n  in  7  segment lines, active-low (0 = lit). Bit 6 = a, 5 = b, 4 = c, 3 = d, 2 = e, 1 = f, 0 = g.
- digit  out  4  decoded code; meaningful only while digit_valid = 1.
- digit_valid  out  1  holding register contains an unconsumed code.
- digit_ready  in  1  consumer accepts the code when digit_valid and digit_ready are both 1 at a clock edge.
- err  out  1  one-cycle pulse: a stable pattern is not in the 7447 table.
- ovr  out  1  one-cycle pulse: a decoded code was dropped because the holding register was full.

Behaviour:
- Reset values (async assert, sync release): seg_q = 7'h7F, cnt = 0, digit = 0, digit_valid = 0, err = 0, ovr = 0.
- Capture register: seg_q <= seg_n on every clock edge.
- Stability counter, evaluated each edge:
  - seg_n != seg_q: cnt <= 0.
  - seg_n == seg_q and cnt < STABLE_CYCLES: cnt <= cnt + 1.
  - Otherwise cnt holds (saturates).
- Accept event = (seg_n == seg_q) and (cnt == STABLE_CYCLES-1).
  - Fires exactly once per stable run.
  - A pattern that changes and then returns is re-accepted.
- Latency: pattern first present before edge k is captured at edge k; accept occurs at edge k+STABLE_CYCLES. digit_valid/err/ovr are visible after that edge.
- Decode table, active-low seg_n value (hex) -> code:
  - 01->0, 4F->1, 12->2, 06->3, 4C->4, 24->5, 60->6, 0F->7
  - 00->8, 0C->9, 72->10, 66->11, 5C->12, 34->13, 70->14, 7F->15
  - Any other value is invalid.
- Output state machine, two states:
  - EMPTY: digit_valid = 0. Accept of a valid pattern loads digit and moves to FULL.
  - FULL: digit_valid = 1. Handshake moves to EMPTY unless a valid accept occurs on the same edge.
    - Handshake and valid accept on the same edge: new code loaded, state stays FULL, no ovr.
    - Valid accept without handshake: old digit kept, ovr = 1 for one cycle.
- Invalid accept: err = 1 for one cycle. digit and state unchanged. No ovr, even if FULL.
- digit is stable while digit_valid = 1 and no handshake has occurred.
- Blank input (7F) after reset is a legal pattern: code 15 is reported after STABLE_CYCLES cycles.
- Reset mid-operation: all state returns to reset values immediately. A pending code is lost. Counting restarts after release.
- STABLE_CYCLES = 1: accept on the first edge where seg_n equals the previously captured value.

Test Plan (STABLE_CYCLES = 4):
- Reset with seg_n = 7F, digit_ready = 0 -> digit_valid rises 4 edges after reset release with digit = 15. Held with no further pulses.
- Drive 06 for 10 cycles, then ready = 1 for one cycle -> digit_valid rises at the 4th edge after capture with digit = 3. Drops on the edge after the handshake. No second report.
- Drive 12, toggle to 01 for 2 cycles, back to 12 -> 01 is never reported. 12 is reported once, 4 edges after its return. The initial 12 run is also reported if it lasted 4 edges.
- Drive 55 stable -> err pulses high for exactly one cycle. digit_valid unchanged. ovr = 0.
- Holding digit 8 with ready = 0, a stable 0C arrives -> ovr pulses once and digit stays 8. Repeat with ready = 1 on the accept edge -> digit becomes 9, digit_valid stays 1, ovr = 0.
- Assert rst_n = 0 mid-count and while FULL -> digit_valid, err and ovr are 0 immediately (asynchronously). After release, the same stable input is re-reported 4 edges later.
